// File: rtl/avalon_st_loopback_fifo.sv
// Avalon-ST store-and-forward loopback FIFO.
// RX packets are written behind a commit pointer and become visible to TX
// only once their eop arrives clean; errored, aborted or oversized packets
// are rewound instead of back-pressuring the MAC.
module avalon_st_loopback_fifo #(
  parameter int DEPTH = 512
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        lpbk_en,
  input  logic        clr_cnt,
  input  logic [63:0] avl_st_rx_data,
  input  logic [2:0]  avl_st_rx_empty,
  input  logic        avl_st_rx_sop,
  input  logic        avl_st_rx_eop,
  input  logic        avl_st_rx_val,
  input  logic [5:0]  avl_st_rx_error,
  output logic        avl_st_rx_rdy,
  output logic [63:0] avl_st_tx_data,
  output logic [2:0]  avl_st_tx_empty,
  output logic        avl_st_tx_sop,
  output logic        avl_st_tx_eop,
  output logic        avl_st_tx_val,
  output logic        avl_st_tx_error,
  input  logic        avl_st_tx_rdy,
  output logic [31:0] fwd_cnt,
  output logic [31:0] drop_cnt,
  output logic [12:0] fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] L_DEPTH = (PW)'(DEPTH);
  localparam logic [PW-1:0] L_ONE   = (PW)'(1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_DROP} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_cp;
  logic [PW-1:0]   r_rp;
  logic [68:0]     r_mem [DEPTH];
  logic [63:0]     r_tx_data;
  logic [2:0]      r_tx_empty;
  logic            r_tx_sop;
  logic            r_tx_eop;
  logic            r_tx_val;
  logic            r_rx_rdy;
  logic [31:0]     r_fwd_cnt;
  logic [31:0]     r_drop_cnt;

  logic [68:0]     w_rx_word;
  logic [68:0]     w_rd_word;
  logic            w_err;
  logic            w_start;
  logic            w_full_wp;
  logic            w_full_cp;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;
  logic [1:0]      w_drop_n;
  logic            w_tx_load;
  logic            w_fwd_ev;
  logic [PW-1:0]   w_level;

  // Saturating counter increment; counters stick at all-ones.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, inc};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign w_rx_word = {avl_st_rx_data, avl_st_rx_empty, avl_st_rx_sop, avl_st_rx_eop};
  assign w_err     = |avl_st_rx_error;
  assign w_start   = avl_st_rx_val & avl_st_rx_sop & lpbk_en;
  // Full uses the registered read pointer: a same-cycle read does not make room.
  assign w_full_wp = ((r_wp - r_rp) == L_DEPTH);
  assign w_full_cp = ((r_cp - r_rp) == L_DEPTH);
  assign w_rd_word = r_mem[r_rp[AW-1:0]];
  assign w_tx_load = (~r_tx_val | avl_st_tx_rdy) & (r_rp != r_cp);
  assign w_fwd_ev  = r_tx_val & avl_st_tx_rdy & r_tx_eop;
  assign w_level   = r_wp - r_rp;

  // Decode this cycle's RAM write and how many packets get dropped.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_wp[AW-1:0];
    w_drop_n  = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_full_cp) begin
            w_drop_n = 2'd1;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_cp[AW-1:0];
            if (avl_st_rx_eop && w_err) w_drop_n = 2'd1;
          end
        end
      end
      S_WR: begin
        if (avl_st_rx_val) begin
          if (avl_st_rx_sop) begin
            // The abandoned partial packet always counts; a restarted packet
            // that is itself dropped in the same cycle counts as a second one.
            w_drop_n = 2'd1;
            if (lpbk_en) begin
              if (w_full_cp) begin
                w_drop_n = 2'd2;
              end else begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_cp[AW-1:0];
                if (avl_st_rx_eop && w_err) w_drop_n = 2'd2;
              end
            end
          end else if (w_full_wp) begin
            w_drop_n = 2'd1;
          end else begin
            w_wr_en = 1'b1;
            if (avl_st_rx_eop && w_err) w_drop_n = 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Packet RAM write port; contents are don't-care until committed.
  always_ff @(posedge clk_in) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_rx_word;
  end

  // Write FSM: owns write and commit pointers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wp    <= '0;
      r_cp    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_full_cp) begin
              r_wp <= r_cp;
              if (!avl_st_rx_eop) r_state <= S_DROP;
            end else if (avl_st_rx_eop) begin
              if (w_err) begin
                r_wp <= r_cp;
              end else begin
                r_wp <= r_cp + L_ONE;
                r_cp <= r_cp + L_ONE;
              end
            end else begin
              r_wp    <= r_cp + L_ONE;
              r_state <= S_WR;
            end
          end
        end
        S_WR: begin
          if (avl_st_rx_val) begin
            if (avl_st_rx_sop) begin
              if (!lpbk_en) begin
                r_wp    <= r_cp;
                r_state <= S_IDLE;
              end else if (w_full_cp) begin
                r_wp    <= r_cp;
                r_state <= avl_st_rx_eop ? S_IDLE : S_DROP;
              end else if (avl_st_rx_eop) begin
                if (w_err) begin
                  r_wp <= r_cp;
                end else begin
                  r_wp <= r_cp + L_ONE;
                  r_cp <= r_cp + L_ONE;
                end
                r_state <= S_IDLE;
              end else begin
                r_wp <= r_cp + L_ONE;
              end
            end else if (w_full_wp) begin
              r_wp    <= r_cp;
              r_state <= avl_st_rx_eop ? S_IDLE : S_DROP;
            end else if (avl_st_rx_eop) begin
              if (w_err) begin
                r_wp <= r_cp;
              end else begin
                r_wp <= r_wp + L_ONE;
                r_cp <= r_wp + L_ONE;
              end
              r_state <= S_IDLE;
            end else begin
              r_wp <= r_wp + L_ONE;
            end
          end
        end
        S_DROP: begin
          if (avl_st_rx_val && avl_st_rx_eop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // TX output stage: refills when empty or when the held word is taken.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_rp       <= '0;
      r_tx_val   <= 1'b0;
      r_tx_data  <= '0;
      r_tx_empty <= '0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
    end else if (w_tx_load) begin
      {r_tx_data, r_tx_empty, r_tx_sop, r_tx_eop} <= w_rd_word;
      r_tx_val <= 1'b1;
      r_rp     <= r_rp + L_ONE;
    end else if (r_tx_val && avl_st_tx_rdy) begin
      r_tx_val <= 1'b0;
    end
  end

  // Forwarded/dropped packet counters; clear wins over increment.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (clr_cnt) begin
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_fwd_cnt  <= sat_add(r_fwd_cnt, {1'b0, w_fwd_ev});
      r_drop_cnt <= sat_add(r_drop_cnt, w_drop_n);
    end
  end

  // RX is always ready once out of reset; overflow is handled by dropping.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) r_rx_rdy <= 1'b0;
    else          r_rx_rdy <= 1'b1;
  end

  assign avl_st_rx_rdy   = r_rx_rdy;
  assign avl_st_tx_data  = r_tx_data;
  assign avl_st_tx_empty = r_tx_empty;
  assign avl_st_tx_sop   = r_tx_sop;
  assign avl_st_tx_eop   = r_tx_eop;
  assign avl_st_tx_val   = r_tx_val;
  assign avl_st_tx_error = 1'b0;
  assign fwd_cnt         = r_fwd_cnt;
  assign drop_cnt        = r_drop_cnt;
  assign fifo_level      = 13'(w_level);

endmodule

// File: tb/tb_avalon_st_loopback_fifo.sv
// Bench for avalon_st_loopback_fifo: packet-level reference model feeding a
// scoreboard queue, with an independent TX monitor popping and comparing.
module tb_avalon_st_loopback_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lpbk_en = 1'b0;
  logic        clr_cnt = 1'b0;
  logic [63:0] rx_data = '0;
  logic [2:0]  rx_empty = '0;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic        rx_val = 1'b0;
  logic [5:0]  rx_error = '0;
  logic        rx_rdy;
  logic [63:0] tx_data;
  logic [2:0]  tx_empty;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_val;
  logic        tx_error;
  logic        tx_rdy = 1'b1;
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic [12:0] fifo_level;

  avalon_st_loopback_fifo #(.DEPTH(DEPTH)) dut (
    .clk_in(clk), .reset_n(reset_n), .lpbk_en(lpbk_en), .clr_cnt(clr_cnt),
    .avl_st_rx_data(rx_data), .avl_st_rx_empty(rx_empty), .avl_st_rx_sop(rx_sop),
    .avl_st_rx_eop(rx_eop), .avl_st_rx_val(rx_val), .avl_st_rx_error(rx_error),
    .avl_st_rx_rdy(rx_rdy),
    .avl_st_tx_data(tx_data), .avl_st_tx_empty(tx_empty), .avl_st_tx_sop(tx_sop),
    .avl_st_tx_eop(tx_eop), .avl_st_tx_val(tx_val), .avl_st_tx_error(tx_error),
    .avl_st_tx_rdy(tx_rdy),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  logic [68:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int cyc = 0;
  int mode = 0;          // 0: rdy=1, 1: random, 2: toggle, 3: rdy=0
  int eop_cyc = -1;
  int first_cyc = -1;
  bit first_seen = 1'b0;
  bit prev_stall = 1'b0;
  logic [68:0] prev_word = '0;

  function automatic void chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = 1'($urandom_range(0, 1));
      2:       tx_rdy = ~tx_rdy;
      default: tx_rdy = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every TX handshake, checks stall hold.
  always @(negedge clk) begin
    logic [68:0] w;
    w = {tx_data, tx_empty, tx_sop, tx_eop};
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 72'({tx_val, w}), 72'({1'b1, prev_word}));
      if (tx_val && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (tx_val && tx_rdy) begin
        chk("tx_error", 72'(tx_error), 72'(0));
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got %0h expected no word", w);
        end else begin
          chk("tx_word", 72'(w), 72'(exp_q.pop_front()));
        end
      end
      prev_stall = tx_val && !tx_rdy;
      prev_word  = w;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rx();
    rx_val = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_error = '0;
  endtask

  task automatic wait_room(input int len);
    int n = 0;
    while (exp_q.size() + len > DEPTH && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("room_timeout", 72'(exp_q.size()), 72'(0));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 72'(exp_q.size()), 72'(0));
    repeat (4) tick();
  endtask

  // Model: a packet reaches TX iff enabled at sop, clean at eop and (when sent
  // into a drained FIFO with TX stalled) no longer than DEPTH.
  task automatic send_pkt(input int len, input logic [5:0] err, input bit en,
                          input bit en_off_mid, input bit stalled_empty);
    logic [68:0] words[$];
    bit dropped;
    dropped = !en || (err != 0) || (stalled_empty && len > DEPTH);
    if (!stalled_empty) wait_room(len);
    lpbk_en = en;
    for (int i = 0; i < len; i++) begin
      rx_data  = {$urandom, $urandom};
      rx_empty = (i == len - 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      rx_sop   = (i == 0);
      rx_eop   = (i == len - 1);
      rx_val   = 1'b1;
      rx_error = (i == len - 1) ? err : 6'd0;
      if (en_off_mid && i == 1) lpbk_en = 1'b0;
      words.push_back({rx_data, rx_empty, rx_sop, rx_eop});
      if (rx_eop) begin
        if (eop_cyc < 0) eop_cyc = cyc;
        if (!dropped) begin
          foreach (words[k]) exp_q.push_back(words[k]);
          exp_fwd++;
        end
      end
      tick();
    end
    idle_rx();
    lpbk_en = 1'b1;
    if (en && dropped) exp_drop++;
  endtask

  // Partial packet cut short by the next sop: counts as one drop.
  task automatic send_partial(input int len);
    wait_room(len + 8);
    lpbk_en = 1'b1;
    for (int i = 0; i < len; i++) begin
      rx_data = {$urandom, $urandom};
      rx_empty = '0; rx_sop = (i == 0); rx_eop = 1'b0; rx_val = 1'b1; rx_error = '0;
      tick();
    end
    idle_rx();
    exp_drop++;
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_fwd"}, 72'(fwd_cnt), 72'(exp_fwd));
    chk({nm, "_drop"}, 72'(drop_cnt), 72'(exp_drop));
    chk({nm, "_level"}, 72'(fifo_level), 72'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 72'({tx_val, tx_sop, tx_eop, tx_empty, tx_data}), 72'(0));
    chk("rst_cnt", 72'({fwd_cnt, drop_cnt}), 72'(0));
    chk("rst_level_rdy", 72'({fifo_level, rx_rdy}), 72'(0));
    reset_n = 1'b1;
    lpbk_en = 1'b1;
    tick();
    chk("rx_rdy", 72'(rx_rdy), 72'(1));

    // Three clean 8-word packets, TX always ready
    mode = 0;
    for (int p = 0; p < 3; p++) send_pkt(8, 6'd0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("first_sop_latency", 72'(first_cyc - eop_cyc), 72'(2));
    chk_counts("three_pkts");

    // Errored packet then clean packet
    send_pkt(4, 6'h01, 1'b1, 1'b0, 1'b0);
    send_pkt(2, 6'd0, 1'b1, 1'b0, 1'b0);
    drain();
    chk_counts("err_drop");

    // sop arriving mid-packet aborts the partial one
    send_partial(3);
    send_pkt(5, 6'd0, 1'b1, 1'b0, 1'b0);
    drain();
    chk_counts("sop_abort");

    // lpbk_en falling mid-packet does not abort it
    send_pkt(4, 6'd0, 1'b1, 1'b1, 1'b0);
    drain();
    chk_counts("en_off_mid");

    // Oversized packet with TX stalled, then a small one
    mode = 3;
    repeat (2) tick();
    send_pkt(20, 6'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    chk("ovf_drop", 72'(drop_cnt), 72'(exp_drop));
    chk("ovf_level", 72'(fifo_level), 72'(0));
    chk("ovf_no_tx", 72'(tx_val), 72'(0));
    send_pkt(4, 6'd0, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    chk("stalled_level", 72'(fifo_level), 72'(3));
    mode = 0;
    drain();
    chk_counts("ovf_after");

    // Counter clear, toggled ready, clear racing an eop handshake
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    exp_fwd = 0;
    exp_drop = 0;
    chk_counts("clr");
    mode = 2;
    send_pkt(6, 6'd0, 1'b1, 1'b0, 1'b0);
    drain();
    chk_counts("toggle");
    send_pkt(3, 6'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_val && tx_rdy && tx_eop) && n < 200);
    if (n >= 200) chk("clr_race_timeout", 72'(n), 72'(0));
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    exp_fwd = 0;
    exp_drop = 0;
    drain();
    chk_counts("clr_race");

    // Randomized traffic with random TX backpressure
    mode = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      logic [5:0] err;
      bit en;
      bit mid;
      len = $urandom_range(1, 6);
      err = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      en  = ($urandom_range(0, 7) != 0);
      mid = en && ($urandom_range(0, 5) == 0);
      send_pkt(len, err, en, mid, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    mode = 0;
    repeat (4) tick();
    chk_counts("random");

    // Reset in the middle of a packet
    lpbk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = {$urandom, $urandom};
      rx_empty = '0; rx_sop = (i == 0); rx_eop = 1'b0; rx_val = 1'b1; rx_error = '0;
      if (i < 3) tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_tx", 72'({tx_val, tx_sop, tx_eop, tx_empty, tx_data}), 72'(0));
    chk("midrst_cnt", 72'({fwd_cnt, drop_cnt}), 72'(0));
    chk("midrst_level_rdy", 72'({fifo_level, rx_rdy}), 72'(0));
    exp_fwd = 0;
    exp_drop = 0;
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = {$urandom, $urandom};
      rx_sop = 1'b0; rx_eop = 1'b1; rx_val = 1'b1;
      tick();
    end
    idle_rx();
    repeat (6) tick();
    chk("postrst_no_tx", 72'(tx_val), 72'(0));
    chk_counts("postrst");
    send_pkt(3, 6'd0, 1'b1, 1'b0, 1'b0);
    drain();
    chk_counts("postrst_pkt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
